restoring_divider: RTL

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 133 +++++++++++++
 1 files changed

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, with divide-by-zero and overflow fast paths.
module restoring_divider #(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] M,
  input  logic [W-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   A,
  output logic [W-1:0]   R,
  output logic           ovf,
  output logic           dz
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  part_q, part_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  div_q, div_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  r_q, r_d;
  logic          ovf_q, ovf_d;
  logic          dz_q, dz_d;

  // The partial remainder is always < divisor, so W bits hold it; only the
  // shifted value needs the extra bit before the compare.
  logic [W:0]    shifted;
  logic [W-1:0]  diff;
  logic          fits;

  always_comb begin
    shifted = {part_q, dvd_q[W-1]};
    fits    = (shifted >= {1'b0, div_q});
    diff    = shifted[W-1:0] - div_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    quo_d   = quo_q;
    a_d     = a_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          part_d  = M[2*W-1:W];
          dvd_d   = M[W-1:0];
          div_d   = B;
          quo_d   = '0;
          cnt_d   = CW'(W);
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          state_d = RUN;
          if (B == '0) begin
            dz_d    = 1'b1;
            a_d     = '1;
            r_d     = '0;
            state_d = DONE;
          end else if (M[2*W-1:W] >= B) begin
            ovf_d   = 1'b1;
            a_d     = '1;
            r_d     = '0;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        part_d = fits ? diff : shifted[W-1:0];
        quo_d  = {quo_q[W-2:0], fits};
        dvd_d  = {dvd_q[W-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          a_d     = quo_d;
          r_d     = part_d;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      a_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      a_q     <= a_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign A    = a_q;
  assign R    = r_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule
